// File: rtl/dz_pkg.sv
// Shared constants for the dot-matrix scan driver: glyph bitmaps, colour encoding, row count.
package dz_pkg;

  localparam int unsigned ROWS = 8;

  typedef enum logic [1:0] {
    OFF,
    RED,
    GREEN,
    YELLOW
  } colour_e;

  // Digits 0-4, rows top to bottom, bit 7 = leftmost column.
  localparam logic [7:0] GLYPH [0:4][0:7] = '{
    '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h3C, 8'h00},
    '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},
    '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
    '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00}
  };

  function automatic colour_e colour_of(logic [2:0] n);
    colour_e c;
    case (n)
      3'd0, 3'd1: c = RED;
      3'd2:       c = YELLOW;
      3'd3, 3'd4: c = GREEN;
      default:    c = OFF;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dz_glyph_rom.sv
// Combinational glyph lookup: (digit, row) -> column pattern; digits above 4 are blank.
module dz_glyph_rom
  import dz_pkg::*;
(
  input  logic [2:0] num_i,
  input  logic [2:0] row_idx_i,
  output logic [7:0] pat_o
);

  always_comb begin
    pat_o = 8'h00;
    if (num_i <= 3'd4) begin
      pat_o = GLYPH[num_i][row_idx_i];
    end
  end

endmodule

// File: rtl/dz_scan_driver.sv
// Row-multiplexed 8x8 red/green digit display; the shown value is latched only at frame ends.
// Optional blinking of digit 0 is enabled by defining DZ_BLINK_EN.
module dz_scan_driver
  import dz_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] num,
  output logic [7:0] row,
  output logic [7:0] colr,
  output logic [7:0] colg
);

  localparam logic [7:0] DivLast = 8'(SCAN_DIV - 1);

  logic [7:0] div_q, div_d;
  logic [2:0] row_idx_q, row_idx_d;
  logic [2:0] num_lat_q, num_lat_d;
  logic [7:0] row_q, row_d;
  logic [7:0] colr_q, colr_d;
  logic [7:0] colg_q, colg_d;
  logic [7:0] pat;
  logic       row_step;
  logic       frame_end;
  logic       blank;
  colour_e    colour;

  assign row_step  = (div_q == DivLast);
  assign frame_end = row_step && (row_idx_q == 3'(ROWS - 1));
  assign colour    = colour_of(num_lat_q);

  dz_glyph_rom u_rom (
    .num_i     (num_lat_q),
    .row_idx_i (row_idx_q),
    .pat_o     (pat)
  );

`ifdef DZ_BLINK_EN
  localparam int unsigned FrmW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FrmW-1:0] FrmLast = FrmW'(BLINK_FRAMES - 1);

  logic [FrmW-1:0] frm_q, frm_d;
  logic            blink_off_q, blink_off_d;

  always_comb begin
    frm_d       = frm_q;
    blink_off_d = blink_off_q;
    if (frame_end) begin
      if (frm_q == FrmLast) begin
        frm_d       = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
      // A non-zero digit always starts its frame visible.
      if (num != 3'd0) begin
        blink_off_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frm_q       <= '0;
      blink_off_q <= 1'b0;
    end else begin
      frm_q       <= frm_d;
      blink_off_q <= blink_off_d;
    end
  end

  assign blank = (num_lat_q == 3'd0) && blink_off_q;
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = ^BLINK_FRAMES;
  assign blank = 1'b0;
`endif

  always_comb begin
    div_d     = div_q + 8'd1;
    row_idx_d = row_idx_q;
    num_lat_d = num_lat_q;
    if (row_step) begin
      div_d     = 8'd0;
      row_idx_d = row_idx_q + 3'd1;
    end
    if (frame_end) begin
      num_lat_d = num;
    end

    // Row select and columns share one register stage so they never disagree.
    row_d  = ~(8'd1 << row_idx_q);
    colr_d = 8'h00;
    colg_d = 8'h00;
    unique case (colour)
      RED:    colr_d = pat;
      GREEN:  colg_d = pat;
      YELLOW: begin
        colr_d = pat;
        colg_d = pat;
      end
      default: ;
    endcase
    if (blank) begin
      colr_d = 8'h00;
      colg_d = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= 8'd0;
      row_idx_q <= 3'd0;
      num_lat_q <= num;
      row_q     <= 8'hFF;
      colr_q    <= 8'h00;
      colg_q    <= 8'h00;
    end else begin
      div_q     <= div_d;
      row_idx_q <= row_idx_d;
      num_lat_q <= num_lat_d;
      row_q     <= row_d;
      colr_q    <= colr_d;
      colg_q    <= colg_d;
    end
  end

  assign row  = row_q;
  assign colr = colr_q;
  assign colg = colg_q;

endmodule

// File: tb/tb_dz_scan_driver.sv
// Directed bench for dz_scan_driver: one DUT at SCAN_DIV=1, a second at SCAN_DIV=4.
module tb_dz_scan_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] num = 3'd0;
  logic [7:0] row, colr, colg;
  logic [7:0] row4, colr4, colg4;

  int checks   = 0;
  int failures = 0;

  logic [7:0] GL [5][8] = '{
    '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h3C, 8'h00},
    '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},
    '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
    '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00}
  };

  always #5 clk = ~clk;

  dz_scan_driver #(.SCAN_DIV(1), .BLINK_FRAMES(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .num  (num),
    .row  (row),
    .colr (colr),
    .colg (colg)
  );

  dz_scan_driver #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut4 (
    .clk  (clk),
    .rst  (rst),
    .num  (num),
    .row  (row4),
    .colr (colr4),
    .colg (colg4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges with num=n; next edge is row 0 of a frame showing n.
  task automatic reset_to(input logic [2:0] n);
    rst = 1'b1;
    num = n;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    num = 3'd4;
    tick();
    tick();
    checks++;
    if ({row, colr, colg} !== 24'hFF_00_00) begin
      failures++;
      $display("FAIL reset_div1 got=%h exp=%h", {row, colr, colg}, 24'hFF_00_00);
    end
    checks++;
    if ({row4, colr4, colg4} !== 24'hFF_00_00) begin
      failures++;
      $display("FAIL reset_div4 got=%h exp=%h", {row4, colr4, colg4}, 24'hFF_00_00);
    end
  endtask

  task automatic test_digit4_green();
    logic [23:0] exp;
    reset_to(3'd4);
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = {~(8'd1 << i), 8'h00, GL[4][i]};
      checks++;
      if ({row, colr, colg} !== exp) begin
        failures++;
        $display("FAIL digit4 row%0d got=%h exp=%h", i, {row, colr, colg}, exp);
      end
    end
  endtask

  task automatic test_yellow();
    logic [23:0] exp;
    reset_to(3'd2);
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = {~(8'd1 << i), GL[2][i], GL[2][i]};
      checks++;
      if ({row, colr, colg} !== exp) begin
        failures++;
        $display("FAIL yellow row%0d got=%h exp=%h", i, {row, colr, colg}, exp);
      end
    end
  endtask

  task automatic test_midframe_change();
    logic [23:0] exp;
    reset_to(3'd4);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) num = 3'd3;
      tick();
      exp = {~(8'd1 << i), 8'h00, GL[4][i]};
      checks++;
      if ({row, colr, colg} !== exp) begin
        failures++;
        $display("FAIL midframe_hold row%0d got=%h exp=%h", i, {row, colr, colg}, exp);
      end
    end
    tick();
    checks++;
    if ({row, colr, colg} !== 24'hFE_00_3C) begin
      failures++;
      $display("FAIL midframe_apply got=%h exp=%h", {row, colr, colg}, 24'hFE_00_3C);
    end
    // Change lands right before the boundary edge (row 7 being driven).
    for (int i = 1; i < 7; i++) tick();
    num = 3'd2;
    tick();
    checks++;
    if ({row, colr, colg} !== {8'h7F, 8'h00, GL[3][7]}) begin
      failures++;
      $display("FAIL boundary_row7 got=%h exp=%h", {row, colr, colg}, {8'h7F, 8'h00, GL[3][7]});
    end
    tick();
    checks++;
    if ({row, colr, colg} !== 24'hFE_3C_3C) begin
      failures++;
      $display("FAIL boundary_apply got=%h exp=%h", {row, colr, colg}, 24'hFE_3C_3C);
    end
  endtask

  task automatic test_blank_digit();
    logic [23:0] exp;
    reset_to(3'd6);
    for (int i = 0; i < 16; i++) begin
      tick();
      exp = {~(8'd1 << (i % 8)), 16'h0000};
      checks++;
      if ({row, colr, colg} !== exp) begin
        failures++;
        $display("FAIL blank6 step%0d got=%h exp=%h", i, {row, colr, colg}, exp);
      end
    end
  endtask

  task automatic test_midframe_reset();
    reset_to(3'd1);
    tick();
    tick();
    tick();
    rst = 1'b1;
    num = 3'd3;
    tick();
    checks++;
    if ({row, colr, colg} !== 24'hFF_00_00) begin
      failures++;
      $display("FAIL midreset_blank got=%h exp=%h", {row, colr, colg}, 24'hFF_00_00);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({row, colr, colg} !== {8'hFE, 8'h00, GL[3][0]}) begin
      failures++;
      $display("FAIL midreset_restart got=%h exp=%h", {row, colr, colg}, {8'hFE, 8'h00, GL[3][0]});
    end
  endtask

  task automatic test_scan_div4();
    logic [23:0] exp;
    reset_to(3'd1);
    for (int k = 0; k < 33; k++) begin
      tick();
      exp = {~(8'd1 << ((k / 4) % 8)), GL[1][(k / 4) % 8], 8'h00};
      checks++;
      if ({row4, colr4, colg4} !== exp) begin
        failures++;
        $display("FAIL div4 cycle%0d got=%h exp=%h", k, {row4, colr4, colg4}, exp);
      end
    end
  endtask

  task automatic test_zero_blink();
    logic [23:0] exp;
    logic        lit;
    reset_to(3'd0);
`ifdef DZ_BLINK_EN
    for (int f = 0; f < 8; f++) begin
      lit = ((f / 2) % 2 == 0) || (f == 7);
      for (int i = 0; i < 8; i++) begin
        if (f == 6 && i == 2) num = 3'd1;
        tick();
        if (f == 7)   exp = {~(8'd1 << i), GL[1][i], 8'h00};
        else if (lit) exp = {~(8'd1 << i), GL[0][i], 8'h00};
        else          exp = {~(8'd1 << i), 16'h0000};
        checks++;
        if ({row, colr, colg} !== exp) begin
          failures++;
          $display("FAIL blink frame%0d row%0d got=%h exp=%h", f, i, {row, colr, colg}, exp);
        end
      end
    end
`else
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 8; i++) begin
        tick();
        exp = {~(8'd1 << i), GL[0][i], 8'h00};
        checks++;
        if ({row, colr, colg} !== exp) begin
          failures++;
          $display("FAIL steady0 frame%0d row%0d got=%h exp=%h", f, i, {row, colr, colg}, exp);
        end
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_digit4_green();
    test_yellow();
    test_midframe_change();
    test_blank_digit();
    test_midframe_reset();
    test_scan_div4();
    test_zero_blink();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
